// File: rtl/uart_echo_tester_if.sv
// Control bus for uart_echo_tester: run request in, status and result out.
// start is taken only in a cycle where busy is low; len/seed are sampled with it,
// and results (pass/err_cnt/timeout) are stable from the done pulse until the next taken start.
interface uart_echo_tester_if;
  logic       start;
  logic [7:0] len;
  logic [7:0] seed;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] err_cnt;
  logic       timeout;
  logic [2:0] dbg_state;

  modport master (
    output start, len, seed,
    input  busy, done, pass, err_cnt, timeout, dbg_state
  );

  modport slave (
    input  start, len, seed,
    output busy, done, pass, err_cnt, timeout, dbg_state
  );
endinterface

// File: rtl/uart_echo_tester.sv
// UART loopback tester: sends a payload sequence on txd and checks each echo on rxd.
// Define UART_ECHO_TESTER_LFSR_EN for an LFSR payload sequence instead of incrementing bytes.
module uart_echo_tester #(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int BAUD        = 115200,
  parameter int TIMEOUT_CYC = 20 * (CLK_FREQ / BAUD)
) (
  input  logic clk,
  input  logic rst,
  input  logic rxd,
  output logic txd,
  uart_echo_tester_if.slave ctl
);
  localparam int BIT_CYC = CLK_FREQ / BAUD;
  localparam int HALF    = BIT_CYC / 2;
  localparam int BW      = $clog2(BIT_CYC + 1);
  localparam int TW      = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {IDLE, SEND, WAIT, CHECK, FINISH} state_e;

  state_e        state_q, state_d;
  logic [9:0]    tx_sh_q, tx_sh_d;
  logic [BW-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]    tx_bit_q, tx_bit_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]    payload_q, payload_d;
  logic [8:0]    byte_cnt_q, byte_cnt_d;
  logic [8:0]    len_q, len_d;
  logic [7:0]    err_q, err_d;
  logic          timeout_q, timeout_d;
  logic          pass_q, pass_d;

  logic          rx_s1_q, rx_s2_q, rx_s3_q;
  logic          rx_busy_q, rx_done_q, rx_ferr_q, rx_discard_q;
  logic [BW-1:0] rx_cnt_q;
  logic [3:0]    rx_bit_q;
  logic [7:0]    rx_sh_q, rx_data_q;

  function automatic logic [7:0] next_payload(input logic [7:0] p);
`ifdef UART_ECHO_TESTER_LFSR_EN
    return {1'b0, p[7:1]} ^ (p[0] ? 8'hB8 : 8'h00);
`else
    return p + 8'd1;
`endif
  endfunction

  function automatic logic [7:0] first_payload(input logic [7:0] s);
`ifdef UART_ECHO_TESTER_LFSR_EN
    return (s == 8'h00) ? 8'h01 : s;
`else
    return s;
`endif
  endfunction

  // Receiver: frames that begin outside WAIT are still decoded but flagged for discard.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1_q      <= 1'b1;
      rx_s2_q      <= 1'b1;
      rx_s3_q      <= 1'b1;
      rx_busy_q    <= 1'b0;
      rx_done_q    <= 1'b0;
      rx_ferr_q    <= 1'b0;
      rx_discard_q <= 1'b0;
      rx_cnt_q     <= '0;
      rx_bit_q     <= '0;
      rx_sh_q      <= '0;
      rx_data_q    <= '0;
    end else begin
      rx_s1_q   <= rxd;
      rx_s2_q   <= rx_s1_q;
      rx_s3_q   <= rx_s2_q;
      rx_done_q <= 1'b0;
      if (!rx_busy_q) begin
        if (rx_s3_q && !rx_s2_q) begin
          rx_busy_q    <= 1'b1;
          rx_cnt_q     <= '0;
          rx_bit_q     <= '0;
          rx_discard_q <= (state_q != WAIT);
        end
      end else begin
        if (rx_cnt_q == BW'(BIT_CYC - 1)) begin
          rx_cnt_q <= '0;
          rx_bit_q <= rx_bit_q + 4'd1;
        end else begin
          rx_cnt_q <= rx_cnt_q + BW'(1);
        end
        if (rx_cnt_q == BW'(HALF)) begin
          if (rx_bit_q == 4'd0) begin
            if (rx_s2_q) rx_busy_q <= 1'b0;
          end else if (rx_bit_q == 4'd9) begin
            rx_busy_q <= 1'b0;
            rx_done_q <= 1'b1;
            rx_ferr_q <= !rx_s2_q;
            rx_data_q <= rx_sh_q;
          end else begin
            rx_sh_q <= {rx_s2_q, rx_sh_q[7:1]};
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      tx_sh_q    <= '1;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      to_cnt_q   <= '0;
      payload_q  <= '0;
      byte_cnt_q <= '0;
      len_q      <= '0;
      err_q      <= '0;
      timeout_q  <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_sh_q    <= tx_sh_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      to_cnt_q   <= to_cnt_d;
      payload_q  <= payload_d;
      byte_cnt_q <= byte_cnt_d;
      len_q      <= len_d;
      err_q      <= err_d;
      timeout_q  <= timeout_d;
      pass_q     <= pass_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tx_sh_d    = tx_sh_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    to_cnt_d   = to_cnt_q;
    payload_d  = payload_q;
    byte_cnt_d = byte_cnt_q;
    len_d      = len_q;
    err_d      = err_q;
    timeout_d  = timeout_q;
    pass_d     = pass_q;
    case (state_q)
      IDLE: begin
        if (ctl.start) begin
          state_d    = SEND;
          len_d      = (ctl.len == 8'd0) ? 9'd256 : {1'b0, ctl.len};
          byte_cnt_d = '0;
          err_d      = '0;
          timeout_d  = 1'b0;
          pass_d     = 1'b0;
          payload_d  = first_payload(ctl.seed);
          tx_sh_d    = {1'b1, first_payload(ctl.seed), 1'b0};
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
        end
      end
      SEND: begin
        if (tx_cnt_q == BW'(BIT_CYC - 1)) begin
          tx_cnt_d = '0;
          tx_sh_d  = {1'b1, tx_sh_q[9:1]};
          if (tx_bit_q == 4'd9) begin
            state_d  = WAIT;
            to_cnt_d = '0;
          end else begin
            tx_bit_d = tx_bit_q + 4'd1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + BW'(1);
        end
      end
      WAIT: begin
        if (rx_done_q && !rx_discard_q) begin
          state_d = CHECK;
        end else if (to_cnt_q == TW'(TIMEOUT_CYC)) begin
          state_d   = FINISH;
          timeout_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
        end
      end
      CHECK: begin
        if ((rx_data_q != payload_q || rx_ferr_q) && err_q != 8'hFF) err_d = err_q + 8'd1;
        payload_d  = next_payload(payload_q);
        byte_cnt_d = byte_cnt_q + 9'd1;
        if (byte_cnt_d == len_q) begin
          state_d = FINISH;
        end else begin
          state_d  = SEND;
          tx_sh_d  = {1'b1, next_payload(payload_q), 1'b0};
          tx_cnt_d = '0;
          tx_bit_d = '0;
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Verdict is registered on entry to FINISH so it is already valid during the done pulse.
    if (state_q != FINISH && state_d == FINISH) pass_d = (err_d == 8'd0) && !timeout_d;
  end

  assign txd           = (state_q == SEND) ? tx_sh_q[0] : 1'b1;
  assign ctl.busy      = (state_q != IDLE);
  assign ctl.done      = (state_q == FINISH);
  assign ctl.pass      = pass_q;
  assign ctl.err_cnt   = err_q;
  assign ctl.timeout   = timeout_q;
  assign ctl.dbg_state = state_q;
endmodule
